sitcp_tcp_tx_pattern_gen: RTL and testbench

- Sits directly downstream of the SiTCP GMII wrapper on the CLK200M user side.
- Consumes the RBCP register-access interface: a 16-byte control/status register window.
- Drives the TCP TX FIFO interface with a software-controlled test stream (incrementing byte or 8-bit LFSR), either a fixed byte count or continuous.
- Also answers the TCP close handshake.

---
 rtl/sitcp_tcp_tx_pattern_gen.sv | 155 +++++++++++++++
 tb/tb_sitcp_tcp_tx_pattern_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sitcp_tcp_tx_pattern_gen.sv
// sitcp_tcp_tx_pattern_gen: RBCP-controlled TCP TX test-pattern source with close handshake
module sitcp_tcp_tx_pattern_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  VERSION   = 8'h01
) (
    input  logic        CLK200M,
    input  logic        SYS_RST,
    input  logic        SiTCP_RST,
    input  logic        TCP_OPEN_ACK,
    input  logic        TCP_CLOSE_REQ,
    output logic        TCP_CLOSE_ACK,
    input  logic        TCP_TX_FULL,
    output logic        TCP_TX_WR,
    output logic [7:0]  TCP_TX_DATA,
    input  logic        RBCP_ACT,
    input  logic [31:0] RBCP_ADDR,
    input  logic [7:0]  RBCP_WD,
    input  logic        RBCP_WE,
    input  logic        RBCP_RE,
    output logic        RBCP_ACK,
    output logic [7:0]  RBCP_RD
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] length_q, length_d, sent_q, sent_d, sent_inc;
    logic [23:0] shadow_q, shadow_d;
    logic [7:0]  inc_q, inc_d, lfsr_q, lfsr_d, data_q, data_d, rd_q, rd_d, rd_mux;
    logic        wr_q, wr_d, ack_q, ack_d, close_ack_q, close_ack_d;
    logic        in_win, acc, wr_en, go;
    logic [3:0]  off;

    assign off      = RBCP_ADDR[3:0];
    assign in_win   = RBCP_ACT && (RBCP_ADDR[31:4] == BASE_ADDR[31:4]);
    assign acc      = in_win && (RBCP_WE || RBCP_RE) && !SiTCP_RST;
    assign wr_en    = in_win && RBCP_WE && !SiTCP_RST;
    assign sent_inc = sent_q + 32'd1;
    assign go       = ctrl_q[0] && TCP_OPEN_ACK && !TCP_CLOSE_REQ && (ctrl_q[2] || length_q != 32'd0);

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            4'h0: rd_mux = {5'b0, ctrl_q};
            4'h1: rd_mux = length_q[31:24];
            4'h2: rd_mux = length_q[23:16];
            4'h3: rd_mux = length_q[15:8];
            4'h4: rd_mux = length_q[7:0];
            4'h5: rd_mux = sent_q[31:24];
            4'h6: rd_mux = shadow_q[23:16];
            4'h7: rd_mux = shadow_q[15:8];
            4'h8: rd_mux = shadow_q[7:0];
            4'h9: rd_mux = {4'b0, state_q == DONE, TCP_TX_FULL, TCP_OPEN_ACK, state_q == SEND};
            4'hA: rd_mux = VERSION;
            default: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        length_d = length_q;
        shadow_d = shadow_q;
        if (wr_en) begin
            case (off)
                4'h0: ctrl_d = RBCP_WD[2:0];
                4'h1: length_d[31:24] = RBCP_WD;
                4'h2: length_d[23:16] = RBCP_WD;
                4'h3: length_d[15:8] = RBCP_WD;
                4'h4: length_d[7:0] = RBCP_WD;
                default: ;
            endcase
        end
        // Reading the MSB freezes the lower bytes so a 4-byte readback is coherent
        if (acc && RBCP_RE && off == 4'h5)
            shadow_d = sent_q[23:0];
        ack_d       = acc;
        rd_d        = acc ? rd_mux : 8'h00;
        close_ack_d = TCP_CLOSE_REQ && !SiTCP_RST;
    end

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        inc_d   = inc_q;
        lfsr_d  = lfsr_q;
        wr_d    = 1'b0;
        data_d  = 8'h00;
        if (SiTCP_RST) begin
            state_d = IDLE;
            sent_d  = 32'd0;
            inc_d   = 8'h00;
            lfsr_d  = 8'hFF;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    state_d = SEND;
                    sent_d  = 32'd0;
                    inc_d   = 8'h00;
                    lfsr_d  = 8'hFF;
                end
                SEND: begin
                    if (!ctrl_q[0] || !TCP_OPEN_ACK || TCP_CLOSE_REQ)
                        state_d = IDLE;
                    else if (!ctrl_q[2] && length_q <= sent_q)
                        state_d = DONE;
                    else if (!TCP_TX_FULL) begin
                        wr_d    = 1'b1;
                        data_d  = ctrl_q[1] ? lfsr_q : inc_q;
                        sent_d  = sent_inc;
                        inc_d   = inc_q + 8'd1;
                        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                        state_d = (!ctrl_q[2] && sent_inc == length_q) ? DONE : SEND;
                    end
                end
                DONE: state_d = ctrl_q[0] ? DONE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK200M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q     <= IDLE;
            ctrl_q      <= 3'b0;
            length_q    <= 32'd0;
            sent_q      <= 32'd0;
            shadow_q    <= 24'd0;
            inc_q       <= 8'h00;
            lfsr_q      <= 8'hFF;
            data_q      <= 8'h00;
            wr_q        <= 1'b0;
            ack_q       <= 1'b0;
            rd_q        <= 8'h00;
            close_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            length_q    <= length_d;
            sent_q      <= sent_d;
            shadow_q    <= shadow_d;
            inc_q       <= inc_d;
            lfsr_q      <= lfsr_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            ack_q       <= ack_d;
            rd_q        <= rd_d;
            close_ack_q <= close_ack_d;
        end
    end

    assign TCP_TX_WR     = wr_q;
    assign TCP_TX_DATA   = data_q;
    assign RBCP_ACK      = ack_q;
    assign RBCP_RD       = rd_q;
    assign TCP_CLOSE_ACK = close_ack_q;
endmodule

// File: tb/tb_sitcp_tcp_tx_pattern_gen.sv
// tb_sitcp_tcp_tx_pattern_gen: scoreboard bench for the TCP TX pattern generator
module tb_sitcp_tcp_tx_pattern_gen;
    logic        CLK200M = 0, SYS_RST = 1, SiTCP_RST = 0;
    logic        TCP_OPEN_ACK = 0, TCP_CLOSE_REQ = 0, TCP_TX_FULL = 0;
    logic        TCP_CLOSE_ACK, TCP_TX_WR, RBCP_ACK;
    logic [7:0]  TCP_TX_DATA, RBCP_RD;
    logic        RBCP_ACT = 0, RBCP_WE = 0, RBCP_RE = 0;
    logic [31:0] RBCP_ADDR = 0;
    logic [7:0]  RBCP_WD = 0;

    int         checks = 0, failures = 0, nbytes = 0, bp_viol = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_data = 0;
    bit         sb_on = 1;
    logic       full_at_edge = 0;

    sitcp_tcp_tx_pattern_gen dut (
        .CLK200M(CLK200M), .SYS_RST(SYS_RST), .SiTCP_RST(SiTCP_RST),
        .TCP_OPEN_ACK(TCP_OPEN_ACK), .TCP_CLOSE_REQ(TCP_CLOSE_REQ), .TCP_CLOSE_ACK(TCP_CLOSE_ACK),
        .TCP_TX_FULL(TCP_TX_FULL), .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA),
        .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR), .RBCP_WD(RBCP_WD),
        .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_ACK(RBCP_ACK), .RBCP_RD(RBCP_RD)
    );

    always #5 CLK200M = ~CLK200M;

    always @(posedge CLK200M) full_at_edge <= TCP_TX_FULL;

    always @(negedge CLK200M) begin
        if (TCP_TX_WR === 1'b1) begin
            nbytes++;
            last_data = TCP_TX_DATA;
            if (full_at_edge) bp_viol++;
            if (sb_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected: got WR data %h, required no write", TCP_TX_DATA);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (TCP_TX_DATA !== e) begin
                        failures++;
                        $display("FAIL tx_data: byte %0d got %h required %h", nbytes, TCP_TX_DATA, e);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK200M);
    endtask

    task automatic rbcp(input logic [31:0] a, input bit we, input bit re, input logic [7:0] wd,
                        output bit ack, output logic [7:0] rd, output bit ack2);
        @(negedge CLK200M);
        RBCP_ACT = 1; RBCP_ADDR = a; RBCP_WD = wd; RBCP_WE = we; RBCP_RE = re;
        @(negedge CLK200M);
        ack = RBCP_ACK; rd = RBCP_RD;
        RBCP_ACT = 0; RBCP_WE = 0; RBCP_RE = 0;
        @(negedge CLK200M);
        ack2 = RBCP_ACK;
    endtask

    task automatic reg_wr(input logic [3:0] off, input logic [7:0] d);
        bit a, a2;
        logic [7:0] r;
        rbcp({28'h0, off}, 1, 0, d, a, r, a2);
    endtask

    task automatic reg_rd(input logic [3:0] off, output logic [7:0] v);
        bit a, a2;
        rbcp({28'h0, off}, 0, 1, 8'h00, a, v, a2);
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK200M);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        cycles(3);
        checks++;
        if ({TCP_TX_WR, TCP_TX_DATA, RBCP_ACK, RBCP_RD, TCP_CLOSE_ACK} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {TCP_TX_WR, TCP_TX_DATA, RBCP_ACK, RBCP_RD, TCP_CLOSE_ACK});
        end
        @(negedge CLK200M) SYS_RST = 0;
        cycles(2);
        reg_rd(4'h0, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL reset_ctrl: got %h required 00", v); end
        reg_rd(4'h9, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL reset_status: got %h required 00", v); end
    endtask

    task automatic test_regs;
        logic [7:0] lb [4];
        logic [7:0] v;
        bit a, a2;
        lb[0] = 8'h00; lb[1] = 8'h00; lb[2] = 8'h01; lb[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            rbcp(32'(i + 1), 1, 0, lb[i], a, v, a2);
            checks++;
            if (a !== 1'b1 || a2 !== 1'b0) begin
                failures++;
                $display("FAIL wr_ack_len%0d: got ack=%b next=%b required 1 0", i, a, a2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            reg_rd(4'(i + 1), v);
            checks++;
            if (v !== lb[i]) begin failures++; $display("FAIL rd_len%0d: got %h required %h", i, v, lb[i]); end
        end
        reg_rd(4'hA, v);
        checks++;
        if (v !== 8'h01) begin failures++; $display("FAIL version: got %h required 01", v); end
        rbcp(32'h0000_0010, 0, 1, 8'h00, a, v, a2);
        checks++;
        if (a !== 1'b0 || v !== 8'h00) begin failures++; $display("FAIL out_of_window_rd: got ack=%b rd=%h required 0 00", a, v); end
        rbcp(32'h0000_0010, 1, 0, 8'h07, a, v, a2);
        reg_rd(4'h0, v);
        checks++;
        if (a !== 1'b0 || v !== 8'h00) begin failures++; $display("FAIL out_of_window_wr: got ack=%b ctrl=%h required 0 00", a, v); end
        rbcp(32'h0, 1, 1, 8'h04, a, v, a2);
        checks++;
        if (a !== 1'b1 || a2 !== 1'b0 || v !== 8'h00) begin
            failures++;
            $display("FAIL we_re_same: got ack=%b next=%b rd=%h required 1 0 00", a, a2, v);
        end
        reg_rd(4'h0, v);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL we_re_written: got %h required 04", v); end
        reg_wr(4'h0, 8'h00);
        rbcp(32'hA, 1, 0, 8'h55, a, v, a2);
        reg_rd(4'hA, v);
        checks++;
        if (a !== 1'b1 || v !== 8'h01) begin failures++; $display("FAIL ro_write: got ack=%b ver=%h required 1 01", a, v); end
        reg_rd(4'hB, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL reserved_rd: got %h required 00", v); end
    endtask

    task automatic test_increment;
        logic [7:0] v;
        logic [7:0] es [4];
        bit ok;
        es[0] = 8'h00; es[1] = 8'h00; es[2] = 8'h01; es[3] = 8'h00;
        @(negedge CLK200M) TCP_OPEN_ACK = 1;
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
        nbytes = 0;
        reg_wr(4'h0, 8'h01);
        wait_empty(1000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL inc_drain: got %0d left required 0", exp_q.size()); end
        cycles(5);
        checks++;
        if (nbytes !== 256) begin failures++; $display("FAIL inc_count: got %0d required 256", nbytes); end
        reg_rd(4'h9, v);
        checks++;
        if (v !== 8'h0A) begin failures++; $display("FAIL inc_status: got %h required 0a", v); end
        for (int i = 0; i < 4; i++) begin
            reg_rd(4'(i + 5), v);
            checks++;
            if (v !== es[i]) begin failures++; $display("FAIL inc_sent%0d: got %h required %h", i, v, es[i]); end
        end
        reg_wr(4'h0, 8'h00);
    endtask

    task automatic test_back_pressure;
        bit ok;
        reg_wr(4'h3, 8'h03);
        reg_wr(4'h4, 8'hE8);
        for (int i = 0; i < 1000; i++) exp_q.push_back(8'(i));
        nbytes = 0;
        bp_viol = 0;
        reg_wr(4'h0, 8'h01);
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge CLK200M);
            TCP_TX_FULL = (c % 50) >= 30;
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        TCP_TX_FULL = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_drain: got %0d left required 0", exp_q.size()); end
        cycles(5);
        checks++;
        if (nbytes !== 1000) begin failures++; $display("FAIL bp_count: got %0d required 1000", nbytes); end
        checks++;
        if (bp_viol !== 0) begin failures++; $display("FAIL bp_wr_while_full: got %0d required 0", bp_viol); end
        reg_wr(4'h0, 8'h00);
    endtask

    task automatic test_lfsr;
        logic [7:0] v, l;
        bit ok;
        reg_wr(4'h3, 8'h00);
        reg_wr(4'h4, 8'h04);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFE); exp_q.push_back(8'hFC); exp_q.push_back(8'hF8);
        nbytes = 0;
        reg_wr(4'h0, 8'h03);
        wait_empty(200, ok);
        cycles(5);
        checks++;
        if (!ok || nbytes !== 4) begin failures++; $display("FAIL lfsr4_count: got %0d required 4", nbytes); end
        reg_rd(4'h9, v);
        checks++;
        if (v !== 8'h0A) begin failures++; $display("FAIL lfsr4_status: got %h required 0a", v); end
        reg_wr(4'h0, 8'h00);
        reg_wr(4'h3, 8'h01);
        reg_wr(4'h4, 8'h00);
        l = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(l);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        nbytes = 0;
        reg_wr(4'h0, 8'h03);
        wait_empty(1000, ok);
        cycles(5);
        checks++;
        if (!ok || nbytes !== 256) begin failures++; $display("FAIL lfsr256_count: got %0d required 256", nbytes); end
        checks++;
        if (last_data !== 8'hFF) begin failures++; $display("FAIL lfsr_period: byte 256 got %h required ff", last_data); end
        reg_wr(4'h0, 8'h00);
    endtask

    task automatic test_abort;
        logic [7:0] v;
        for (int i = 0; i < 3000; i++) exp_q.push_back(8'(i));
        reg_wr(4'h0, 8'h05);
        cycles(60);
        checks++;
        if (TCP_TX_WR !== 1'b1 || TCP_CLOSE_ACK !== 1'b0) begin
            failures++;
            $display("FAIL cont_stream: got wr=%b ack=%b required 1 0", TCP_TX_WR, TCP_CLOSE_ACK);
        end
        TCP_CLOSE_REQ = 1;
        @(negedge CLK200M);
        checks++;
        if (TCP_CLOSE_ACK !== 1'b1) begin failures++; $display("FAIL close_ack_rise: got %b required 1", TCP_CLOSE_ACK); end
        checks++;
        if (TCP_TX_WR !== 1'b0) begin failures++; $display("FAIL abort_wr: got %b required 0", TCP_TX_WR); end
        @(negedge CLK200M);
        exp_q.delete();
        reg_rd(4'h9, v);
        checks++;
        if (v !== 8'h02) begin failures++; $display("FAIL abort_status: got %h required 02", v); end
        cycles(10);
        reg_wr(4'h0, 8'h00);
        checks++;
        if (TCP_CLOSE_ACK !== 1'b1) begin failures++; $display("FAIL close_ack_hold: got %b required 1", TCP_CLOSE_ACK); end
        TCP_CLOSE_REQ = 0;
        @(negedge CLK200M);
        checks++;
        if (TCP_CLOSE_ACK !== 1'b0) begin failures++; $display("FAIL close_ack_fall: got %b required 0", TCP_CLOSE_ACK); end
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] v;
        sb_on = 0;
        reg_wr(4'h0, 8'h05);
        cycles(30);
        SYS_RST = 1;
        #1;
        checks++;
        if ({TCP_TX_WR, TCP_TX_DATA, RBCP_ACK, RBCP_RD, TCP_CLOSE_ACK} !== 19'h0) begin
            failures++;
            $display("FAIL sysrst_outputs: got %h required 0", {TCP_TX_WR, TCP_TX_DATA, RBCP_ACK, RBCP_RD, TCP_CLOSE_ACK});
        end
        @(negedge CLK200M) SYS_RST = 0;
        reg_rd(4'h0, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL sysrst_ctrl: got %h required 00", v); end
        reg_wr(4'h0, 8'h05);
        cycles(30);
        checks++;
        if (TCP_TX_WR !== 1'b1) begin failures++; $display("FAIL sitcp_pre_stream: got %b required 1", TCP_TX_WR); end
        SiTCP_RST = 1;
        @(negedge CLK200M) SiTCP_RST = 0;
        checks++;
        if (TCP_TX_WR !== 1'b0) begin failures++; $display("FAIL sitcp_wr: got %b required 0", TCP_TX_WR); end
        for (int i = 5; i <= 8; i++) begin
            reg_rd(4'(i), v);
            checks++;
            if (v !== 8'h00) begin failures++; $display("FAIL sitcp_sent%0d: got %h required 00", i, v); end
        end
        reg_rd(4'h0, v);
        checks++;
        if (v !== 8'h05) begin failures++; $display("FAIL sitcp_ctrl_kept: got %h required 05", v); end
        reg_wr(4'h0, 8'h00);
        cycles(3);
        sb_on = 1;
    endtask

    initial begin
        test_reset;
        test_regs;
        test_increment;
        test_back_pressure;
        test_lfsr;
        test_abort;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
